// File: rtl/alu_arb_pkg.sv
// Shared types for the shared-ALU arbiter: opcodes, response buffer states, id width helper.
// Optional lock feature of the arbiter is enabled with the ALU_ARB_LOCK_EN macro.
package alu_arb_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'd0,
        OP_SUB  = 2'd1,
        OP_EQ   = 2'd2,
        OP_PASS = 2'd3
    } alu_op_e;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_e;

    // An id field is never narrower than one bit, even for a single requester.
    function automatic int id_width(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid index at or after the pointer, wrapping.
// Generic so other arbiters can reuse it.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
) (
    input  logic [IDW-1:0]     i_ptr,
    input  logic [NUM_REQ-1:0] i_valid,
    output logic [IDW-1:0]     o_grant,
    output logic               o_any_valid
);

    // Scan from the farthest offset down so the closest valid index wins last.
    always_comb begin
        int idx;
        idx         = 0;
        o_grant     = '0;
        o_any_valid = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(i_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (i_valid[idx]) begin
                o_grant     = IDW'(idx);
                o_any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one small ALU among NUM_REQ requesters with a one-entry response buffer.
// Define ALU_ARB_LOCK_EN to add req_lock, which lets the accepted requester keep the pointer (bursts).
module alu_share_arbiter
    import alu_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int WIDTH   = 4,
    localparam int IDW     = id_width(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [2*NUM_REQ-1:0]     req_op,
    input  logic [WIDTH*NUM_REQ-1:0] req_a,
    input  logic [WIDTH*NUM_REQ-1:0] req_b,
`ifdef ALU_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]       req_lock,
`endif
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_data,
    output logic [IDW-1:0]           rsp_id
);

    buf_state_e       r_state;
    buf_state_e       w_stateNext;
    logic [IDW-1:0]   r_ptr;
    logic [IDW-1:0]   w_ptrNext;
    logic [IDW-1:0]   w_grant;
    logic             w_anyValid;
    logic             w_canAccept;
    logic             w_accept;
    alu_op_e          w_op;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_aluResult;
    logic [WIDTH-1:0] r_rspData;
    logic [IDW-1:0]   r_rspId;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_pick (
        .i_ptr       (r_ptr),
        .i_valid     (req_valid),
        .o_grant     (w_grant),
        .o_any_valid (w_anyValid)
    );

    // Gating with rst_n keeps req_ready low while reset is held, even though the buffer reads EMPTY.
    assign w_canAccept = rst_n & ((r_state == EMPTY) | rsp_ready);
    assign w_accept    = w_anyValid & w_canAccept;

    always_comb begin
        req_ready = '0;
        if (w_anyValid) begin
            req_ready[w_grant] = w_canAccept;
        end
    end

    assign w_op = alu_op_e'(req_op[2*int'(w_grant) +: 2]);
    assign w_a  = req_a[WIDTH*int'(w_grant) +: WIDTH];
    assign w_b  = req_b[WIDTH*int'(w_grant) +: WIDTH];

    always_comb begin
        w_aluResult = '0;
        case (w_op)
            OP_ADD:  w_aluResult = w_a + w_b;
            OP_SUB:  w_aluResult = w_a - w_b;
            OP_EQ:   w_aluResult = {{(WIDTH-1){1'b0}}, (w_a == w_b)};
            OP_PASS: w_aluResult = w_a;
            default: w_aluResult = '0;
        endcase
    end

    // The pointer only moves on an accept, so a stalled grant keeps its turn.
    always_comb begin
        w_ptrNext = r_ptr;
        if (w_accept) begin
            if (int'(w_grant) == NUM_REQ - 1) begin
                w_ptrNext = '0;
            end else begin
                w_ptrNext = w_grant + 1'b1;
            end
`ifdef ALU_ARB_LOCK_EN
            if (req_lock[w_grant]) begin
                w_ptrNext = w_grant;
            end
`endif
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            EMPTY: begin
                if (w_accept) begin
                    w_stateNext = FULL;
                end
            end
            FULL: begin
                if (!w_accept && rsp_ready) begin
                    w_stateNext = EMPTY;
                end
            end
            default: w_stateNext = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= EMPTY;
            r_ptr     <= '0;
            r_rspData <= '0;
            r_rspId   <= '0;
        end else begin
            r_state <= w_stateNext;
            r_ptr   <= w_ptrNext;
            if (w_accept) begin
                r_rspData <= w_aluResult;
                r_rspId   <= w_grant;
            end
        end
    end

    assign rsp_valid = (r_state == FULL);
    assign rsp_data  = r_rspData;
    assign rsp_id    = r_rspId;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed self-checking bench for alu_share_arbiter (4 requesters, 4-bit ALU).
// Lock scenario is built only when ALU_ARB_LOCK_EN is defined.
module tb_alu_share_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [7:0]  req_op;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [3:0]  rsp_data;
    logic [1:0]  rsp_id;
`ifdef ALU_ARB_LOCK_EN
    logic [3:0]  req_lock;
`endif

    int checks = 0;
    int errors = 0;

    logic [1:0] rrGrant [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [3:0] rrData  [5] = '{4'h2, 4'hF, 4'h7, 4'h1, 4'h2};

    alu_share_arbiter #(
        .NUM_REQ (4),
        .WIDTH   (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
`ifdef ALU_ARB_LOCK_EN
        .req_lock  (req_lock),
`endif
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic setReq(input int i, input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        req_op[2*i +: 2] = op;
        req_a[4*i +: 4]  = a;
        req_b[4*i +: 4]  = b;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
`ifdef ALU_ARB_LOCK_EN
        req_lock  = '0;
`endif
        repeat (2) @(posedge clk);
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        checks++; if (rsp_data !== 4'h0) begin errors++; $display("[TB] FAIL reset_rsp_data: got %h expected 0", rsp_data); end
        checks++; if (rsp_id !== 2'd0) begin errors++; $display("[TB] FAIL reset_rsp_id: got %0d expected 0", rsp_id); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL reset_req_ready: got %b expected 0000", req_ready); end
        req_valid = 4'h0;
        rst_n     = 1'b1;
    endtask

    task automatic test_single();
        setReq(2, 2'd0, 4'h9, 4'h8);
        req_valid = 4'b0100;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("[TB] FAIL single_ready: got %b expected 0100", req_ready); end
        @(posedge clk); #1;
        req_valid = 4'b0000;
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== 4'h1 || rsp_id !== 2'd2) begin errors++; $display("[TB] FAIL single_rsp: got v=%b d=%h id=%0d expected v=1 d=1 id=2", rsp_valid, rsp_data, rsp_id); end
        // With every requester valid the pointer (now 3) decides the grant.
        setReq(3, 2'd3, 4'h6, 4'h0);
        req_valid = 4'hF;
        #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("[TB] FAIL single_ptr_next: got %b expected 1000", req_ready); end
        @(posedge clk); #1;
        req_valid = 4'h0;
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== 4'h6 || rsp_id !== 2'd3) begin errors++; $display("[TB] FAIL single_rsp3: got v=%b d=%h id=%0d expected v=1 d=6 id=3", rsp_valid, rsp_data, rsp_id); end
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_drain: got %b expected 0", rsp_valid); end
    endtask

    task automatic test_round_robin();
        setReq(0, 2'd0, 4'h1, 4'h1);
        setReq(1, 2'd1, 4'h2, 4'h3);
        setReq(2, 2'd3, 4'h7, 4'h5);
        setReq(3, 2'd0, 4'hF, 4'h2);
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++; if (req_ready !== (4'b0001 << rrGrant[k])) begin errors++; $display("[TB] FAIL rr_ready[%0d]: got %b expected %b", k, req_ready, 4'b0001 << rrGrant[k]); end
            @(posedge clk); #1;
            checks++; if (rsp_valid !== 1'b1 || rsp_id !== rrGrant[k] || rsp_data !== rrData[k]) begin errors++; $display("[TB] FAIL rr_rsp[%0d]: got v=%b id=%0d d=%h expected v=1 id=%0d d=%h", k, rsp_valid, rsp_id, rsp_data, rrGrant[k], rrData[k]); end
        end
        req_valid = 4'h0;
    endtask

    task automatic test_back_to_back_stall();
        rsp_ready = 1'b0;
        req_valid = 4'hF;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL stall_ready[%0d]: got %b expected 0000", k, req_ready); end
            @(posedge clk); #1;
            checks++; if (rsp_valid !== 1'b1 || rsp_data !== 4'h2 || rsp_id !== 2'd0) begin errors++; $display("[TB] FAIL stall_hold[%0d]: got v=%b d=%h id=%0d expected v=1 d=2 id=0", k, rsp_valid, rsp_data, rsp_id); end
        end
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("[TB] FAIL stall_release_ready: got %b expected 0010", req_ready); end
        @(posedge clk); #1;
        req_valid = 4'h0;
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== 4'hF || rsp_id !== 2'd1) begin errors++; $display("[TB] FAIL stall_release_rsp: got v=%b d=%h id=%0d expected v=1 d=f id=1", rsp_valid, rsp_data, rsp_id); end
        @(posedge clk); #1;
    endtask

    task automatic test_eq_pass();
        setReq(0, 2'd2, 4'h5, 4'h5);
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL eq_ready: got %b expected 0001", req_ready); end
        @(posedge clk); #1;
        checks++; if (rsp_data !== 4'h1 || rsp_id !== 2'd0) begin errors++; $display("[TB] FAIL eq_true: got d=%h id=%0d expected d=1 id=0", rsp_data, rsp_id); end
        setReq(0, 2'd2, 4'h5, 4'h4);
        @(posedge clk); #1;
        checks++; if (rsp_data !== 4'h0) begin errors++; $display("[TB] FAIL eq_false: got %h expected 0", rsp_data); end
        setReq(0, 2'd3, 4'hC, 4'h3);
        @(posedge clk); #1;
        req_valid = 4'h0;
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== 4'hC) begin errors++; $display("[TB] FAIL pass: got v=%b d=%h expected v=1 d=c", rsp_valid, rsp_data); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        setReq(1, 2'd0, 4'h3, 4'h4);
        req_valid = 4'b0010;
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 4'h0;
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== 4'h7) begin errors++; $display("[TB] FAIL mid_fill: got v=%b d=%h expected v=1 d=7", rsp_valid, rsp_data); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0 || rsp_data !== 4'h0) begin errors++; $display("[TB] FAIL mid_async_clear: got v=%b d=%h expected v=0 d=0", rsp_valid, rsp_data); end
        @(posedge clk); #1;
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_no_rsp[%0d]: got %b expected 0", k, rsp_valid); end
        end
        setReq(0, 2'd0, 4'h2, 4'h2);
        req_valid = 4'hF;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL mid_ptr_zero: got %b expected 0001", req_ready); end
        @(posedge clk); #1;
        req_valid = 4'h0;
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 4'h4) begin errors++; $display("[TB] FAIL mid_first_rsp: got v=%b id=%0d d=%h expected v=1 id=0 d=4", rsp_valid, rsp_id, rsp_data); end
        @(posedge clk); #1;
    endtask

`ifdef ALU_ARB_LOCK_EN
    task automatic test_lock();
        logic [1:0] expId [4];
        expId = '{2'd1, 2'd1, 2'd1, 2'd2};
        setReq(1, 2'd3, 4'hA, 4'h0);
        setReq(2, 2'd3, 4'hB, 4'h0);
        req_valid = 4'b0110;
        req_lock  = 4'b0010;
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k == 2) req_lock = 4'b0000;
            @(posedge clk); #1;
            checks++; if (rsp_valid !== 1'b1 || rsp_id !== expId[k]) begin errors++; $display("[TB] FAIL lock_id[%0d]: got v=%b id=%0d expected v=1 id=%0d", k, rsp_valid, rsp_id, expId[k]); end
        end
        req_valid = 4'h0;
        req_lock  = 4'h0;
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_back_to_back_stall();
        test_eq_pass();
        test_reset_mid();
`ifdef ALU_ARB_LOCK_EN
        test_lock();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one WIDTH-bit ALU (add / subtract / compare / pass) among NUM_REQ requesters.
- Each requester presents operands and an opcode with a valid/ready handshake.
- The block grants one requester per cycle, registers the ALU result into a single-entry response buffer, and returns the result tagged with the requester id.
- Sits between generated datapath clients and the shared arithmetic unit, replacing per-client adders.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 4, operand/result width in bits.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high.
- req_op  in  2*NUM_REQ  opcode, requester i at bits [2i+1:2i].
- req_a  in  WIDTH*NUM_REQ  operand A, requester i at [WIDTH*i +: WIDTH].
- req_b  in  WIDTH*NUM_REQ  operand B, same packing.
- rsp_valid  out  1  response buffer holds a result.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  WIDTH  ALU result.
- rsp_id  out  clog2(NUM_REQ)  index of the requester that produced rsp_data.

Behaviour:
- Reset (rst_n low, asynchronous):
  - rsp_valid=0, rsp_data=0, rsp_id=0.
  - RR pointer=0; state=EMPTY.
  - req_ready is combinational and 0 during reset.
- Opcodes:
  - OP_ADD=0: a+b mod 2^WIDTH (carry dropped).
  - OP_SUB=1: a-b mod 2^WIDTH.
  - OP_EQ=2: zero-extended (a==b).
  - OP_PASS=3: a.
- Buffer FSM, states EMPTY and FULL:
  - can_accept = (state==EMPTY) | rsp_ready.
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on rsp_ready with no accept.
  - FULL -> FULL on rsp_ready with accept, i.e. simultaneous drain and fill gives full throughput of 1 op/cycle.
  - FULL -> FULL holding rsp_data/rsp_id stable while rsp_ready=0.
- Arbitration (combinational):
  - Search req_valid starting at index ptr, wrapping modulo NUM_REQ.
  - The first valid index g is granted.
  - req_ready[g] = can_accept; all other ready bits 0.
  - No valid requests: all ready bits 0.
- Accept = req_valid[g] & req_ready[g]. On accept:
  - rsp_data <= ALU(op_g, a_g, b_g) and rsp_id <= g next edge.
  - rsp_valid=1 the cycle after accept (latency 1).
  - ptr <= (g+1) mod NUM_REQ.
- ptr changes only on accept, so a stalled grant does not rotate.
- Requesters must hold req_valid/op/a/b until accepted. Deasserting before accept is allowed; arbitration re-evaluates each cycle.
- Starvation bound: a continuously valid requester is accepted within NUM_REQ accepts.
- Reset asserted mid-operation: the pending response is discarded, ptr returns to 0, no response is emitted after release.

Optional Feature:
- ALU_ARB_LOCK_EN defined:
  - Adds input req_lock [NUM_REQ].
  - If the accepted requester has req_lock[g]=1, ptr stays at g instead of advancing, so its next request wins again (burst).
  - Lock is released by accepting with req_lock[g]=0, or by req_valid[g] falling with the pointer still at g, after which normal search resumes.
- ALU_ARB_LOCK_EN undefined: no req_lock port; pure round-robin as above.

Decomposition:
- Package alu_arb_pkg:
  - opcode enum (OP_ADD, OP_SUB, OP_EQ, OP_PASS, 2 bits).
  - buffer state enum (EMPTY, FULL).
  - localparam function for id width (clog2 with minimum 1).
- Sub-module rr_pick (ptr, valid vector -> grant index, any_valid):
  - Purely combinational; reused by other arbiters in the codebase.
- ALU is an inline case in the top.

Test Plan:
- Reset then single request: req 2, ADD a=4'h9 b=4'h8 -> rsp_valid next cycle, rsp_data=4'h1, rsp_id=2, ptr=3.
- All four valid continuously, rsp_ready=1, ptr=0:
  - Grants 0,1,2,3,0 on consecutive cycles.
  - One response per cycle.
  - SUB a=4'h2 b=4'h3 from req 1 yields 4'hF.
- Backpressure: rsp_ready=0 for 3 cycles with FULL:
  - rsp_data/rsp_id stable.
  - All req_ready 0.
  - ptr unchanged.
  - Raising rsp_ready accepts the next grant that same cycle.
- EQ/PASS: req 0 EQ a=4'h5 b=4'h5 -> 4'h1; req 0 EQ 4'h5/4'h4 -> 4'h0; PASS a=4'hC -> 4'hC.
- Reset mid-operation: rst_n low while FULL -> rsp_valid drops immediately (asynchronous); after release, rsp_valid stays 0 until a new accept.
- With ALU_ARB_LOCK_EN: req 1 locked for 3 ops while req 2 valid -> ids 1,1,1, then 2 after lock drops.
